hpf_multi: RTL and testbench
============================

# hpf_multi

Parametrised multi-channel first-order DC-blocking high-pass filter for the audio front end. It takes interleaved (TDM) ADC samples over a valid/ready handshake and keeps independent filter state per channel. Each output sample goes through a registered output stage with backpressure and optional saturation. It replaces the single-channel fixed-width HPF, sits between the ADC deserialiser and the feature-extraction pipeline, and adds flush, bypass and a saturation-event counter.

## Interface
- WIDTH, 16, sample width (signed two's complement), 8..32
- CHANNELS, 2, number of interleaved channels, 1..16
- SHIFT, 6, coefficient exponent; a = 1 - 2^-SHIFT, 1..15
- GUARD, 3, extra internal state bits, ≥3
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  WIDTH  signed input sample
- in_chan  in  CW  channel index, CW = max(1, $clog2(CHANNELS))
- bypass  in  1  pass the input through unfiltered, sampled with each accepted sample
- flush  in  1  clear all channel state
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output
- out_data  out  WIDTH  signed filtered sample
- out_chan  out  CW  channel index of out_data
- sat_count  out  16  saturation events since reset or flush, sticks at 0xFFFF

## Operation
- Each channel c holds prev_in[c] (WIDTH bits) and prev_out[c] (IW = WIDTH+GUARD bits, signed). All are 0 after reset.
- Accept happens when in_valid && in_ready. in_chan ≥ CHANNELS is accepted and dropped: no state update, no output.
- Arithmetic at IW bits, sign-extended:
  - diff = in - prev_in[c]
  - sum = prev_out[c] + diff
  - y = sum - (sum >>> SHIFT), arithmetic shift, floor rounding
- State update on accept: prev_in[c] ← in_data and prev_out[c] ← y. The full-precision y is stored, never the saturated output.
- Output: out_data ← y reduced to WIDTH bits (see Configuration), out_chan ← in_chan.
- Bypass: out_data ← in_data, state still updates exactly as in normal mode, so toggling bypass causes no transient.
- Flush, with priority over an accept in the same cycle:
  - zeroes all prev_in, prev_out and sat_count
  - clears out_valid
  - the sample presented that cycle is not accepted (in_ready=0 while flush=1)
- Channels are fully independent. Arbitrary in_chan order is legal, including back-to-back samples on the same channel.

## Timing
- Latency is 1 cycle: the sample accepted at edge N appears on out_data/out_valid after edge N.
- in_ready = !flush && (!out_valid || out_ready), combinational. Throughput is 1 sample/cycle with out_ready held high.
- With out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable and no new sample is accepted.
- Back-to-back same-channel samples see the state written by the previous accept. This needs no hazard bubble, because the state update is in the same edge as the output register.
- Reset values: out_valid=0, out_data=0, out_chan=0, sat_count=0; in_ready=1 one cycle after reset deasserts.
- Reset mid-stream discards any held output and all channel state.

## Configuration
- HPF_SAT_EN defined:
  - y outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] clamps to the nearest bound
  - each clamped output increments sat_count (bypass outputs never count)
- HPF_SAT_EN undefined:
  - out_data = y[WIDTH-1:0] (two's-complement wrap)
  - sat_count tied to 0
  - no clamp logic is synthesised

## Test plan
- Step, ch0, WIDTH=16, SHIFT=6: in 1000,1000,1000 → out 985, 970, 955; ch1 idle, ch1 state stays 0.
- Negative step: ch1 in -1000 → out -984 (floor shift). Interleaving ch0/ch1 reproduces each channel's single-channel sequence exactly.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, out_data stable, no samples lost. After release, outputs match the no-stall reference.
- Saturation (HPF_SAT_EN): ch0 holds 32767 for 400 samples, then -32768 → out_data=-32768, sat_count=1. Without the macro → wrapped value equal to y[15:0].
- Flush/bypass:
  - flush after a ch0 step → next in 1000 gives 985 and sat_count=0
  - bypass=1 with in 1234 → out 1234; the next normal sample continues from the updated state
- Reset mid-stream with out_valid=1 and out_ready=0 → out_valid=0, out_data=0, all state 0; in 1000 then gives out 985.

Source files
------------

// File: rtl/hpf_multi.sv
`default_nettype none
// ============================================================================
//  Module   : hpf_multi
//  Purpose  : Multi-channel TDM first-order DC-blocking high-pass filter with
//             per-channel state, registered output stage and backpressure.
//             Optional output clamping and saturation counting: HPF_SAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module hpf_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int SHIFT    = 6,
    parameter int GUARD    = 3,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic [CW-1:0]           in_chan,
    input  logic                    bypass,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CW-1:0]           out_chan,
    output logic [15:0]             sat_count
);

    localparam int IW = WIDTH + GUARD;

    logic signed [WIDTH-1:0] r_prev_in  [CHANNELS];
    logic signed [IW-1:0]    r_prev_out [CHANNELS];

    logic                    r_out_valid;
    logic signed [WIDTH-1:0] r_out_data;
    logic [CW-1:0]           r_out_chan;

    logic                    w_accept;
    logic                    w_hit;
    logic                    w_update;
    logic signed [WIDTH-1:0] w_pin;
    logic signed [IW-1:0]    w_pout;
    logic signed [IW-1:0]    w_in_ext;
    logic signed [IW-1:0]    w_pin_ext;
    logic signed [IW-1:0]    w_diff;
    logic signed [IW-1:0]    w_sum;
    logic signed [IW-1:0]    w_shr;
    logic signed [IW-1:0]    w_y;
    logic signed [WIDTH-1:0] w_yred;

    assign in_ready  = !flush && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_update  = w_accept && w_hit;

    // Channel state lookup; an index beyond CHANNELS leaves w_hit low so the
    // sample is consumed without touching any state or producing output.
    always_comb begin
        w_hit  = 1'b0;
        w_pin  = '0;
        w_pout = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_chan == CW'(c)) begin
                w_hit  = 1'b1;
                w_pin  = r_prev_in[c];
                w_pout = r_prev_out[c];
            end
        end
    end

    assign w_in_ext  = {{GUARD{in_data[WIDTH-1]}}, in_data};
    assign w_pin_ext = {{GUARD{w_pin[WIDTH-1]}}, w_pin};
    assign w_diff    = w_in_ext - w_pin_ext;
    assign w_sum     = w_pout + w_diff;
    assign w_shr     = w_sum >>> SHIFT;
    assign w_y       = w_sum - w_shr;

`ifdef HPF_SAT_EN
    logic        w_ovf;
    logic [15:0] r_sat_count;

    // Out of range whenever the bits above the output sign bit disagree.
    assign w_ovf  = (w_y[IW-1:WIDTH-1] != {(GUARD + 1){w_y[IW-1]}});
    assign w_yred = !w_ovf           ? w_y[WIDTH-1:0] :
                    w_y[IW-1]        ? {1'b1, {(WIDTH - 1){1'b0}}} :
                                       {1'b0, {(WIDTH - 1){1'b1}}};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_sat_count <= '0;
        end else if (w_update && !bypass && w_ovf && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`else
    assign w_yred    = w_y[WIDTH-1:0];
    assign sat_count = '0;
`endif

    // Full-precision y is always kept as state, independent of bypass or clamp.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_prev_in[c]  <= '0;
                r_prev_out[c] <= '0;
            end
        end else if (w_update) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (in_chan == CW'(c)) begin
                    r_prev_in[c]  <= in_data;
                    r_prev_out[c] <= w_y;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= w_hit;
            if (w_hit) begin
                r_out_data <= bypass ? in_data : w_yred;
                r_out_chan <= in_chan;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_hpf_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hpf_multi
//  Purpose  : Directed self-checking bench for hpf_multi (WIDTH=16, CH=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hpf_multi;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic [0:0]         in_chan;
    logic               bypass;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [0:0]         out_chan;
    logic [15:0]        sat_count;

    int n_vec = 0;
    int n_err = 0;
    int m_pi [2];
    int m_po [2];

    always #5 clk = ~clk;

    hpf_multi #(.WIDTH(16), .CHANNELS(2), .SHIFT(6), .GUARD(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chan   (in_chan),
        .bypass    (bypass),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .sat_count (sat_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int floor_div64(input int s);
        if (s >= 0) return s / 64;
        return -((-s + 63) / 64);
    endfunction

    // Reference filter step; returns full-precision y and updates the model.
    function automatic int model_step(input int c, input int d);
        int sum;
        int y;
        sum = m_po[c] + (d - m_pi[c]);
        y = sum - floor_div64(sum);
        m_pi[c] = d;
        m_po[c] = y;
        return y;
    endfunction

    task automatic send(input int c, input int d, input bit b);
        in_valid = 1'b1;
        in_chan  = c[0:0];
        in_data  = d[15:0];
        bypass   = b;
        tick();
        in_valid = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_pi[c] = 0;
            m_po[c] = 0;
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 16'sd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", out_data); end
        n_vec++; if (out_chan !== 1'b0) begin n_err++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
        n_vec++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL reset_sat: got %0d want 0", sat_count); end
        reset = 1'b0;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_step();
        int exp0 [3] = '{985, 970, 955};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(0, 1000, 1'b0);
            n_vec++;
            if (out_valid !== 1'b1 || out_chan !== 1'b0 || out_data !== exp0[i][15:0]) begin
                n_err++;
                $display("FAIL step_ch0[%0d]: got v=%0b c=%0d d=%0d want v=1 c=0 d=%0d", i, out_valid, out_chan, out_data, exp0[i]);
            end
        end
        send(1, -1000, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_chan !== 1'b1 || out_data !== -16'sd984) begin
            n_err++;
            $display("FAIL negstep_ch1: got v=%0b c=%0d d=%0d want v=1 c=1 d=-984", out_valid, out_chan, out_data);
        end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL step_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_interleave();
        int exp0 [3] = '{985, 970, 955};
        int exp1 [3] = '{-984, -968, -952};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(0, 1000, 1'b0);
            n_vec++;
            if (out_chan !== 1'b0 || out_data !== exp0[i][15:0]) begin
                n_err++;
                $display("FAIL ilv_ch0[%0d]: got c=%0d d=%0d want c=0 d=%0d", i, out_chan, out_data, exp0[i]);
            end
            send(1, -1000, 1'b0);
            n_vec++;
            if (out_chan !== 1'b1 || out_data !== exp1[i][15:0]) begin
                n_err++;
                $display("FAIL ilv_ch1[%0d]: got c=%0d d=%0d want c=1 d=%0d", i, out_chan, out_data, exp1[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_chan   = 1'b0;
        in_data   = 16'sd1000;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'sd985) begin
                n_err++;
                $display("FAIL stall[%0d]: got rdy=%0b v=%0b d=%0d want rdy=0 v=1 d=985", i, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_data !== 16'sd970) begin n_err++; $display("FAIL release_1: got %0d want 970", out_data); end
        tick();
        n_vec++; if (out_data !== 16'sd955) begin n_err++; $display("FAIL release_2: got %0d want 955", out_data); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        send(0, 1000, 1'b0);
        send(0, 1000, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_chan  = 1'b0;
        in_data  = 16'sd1000;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        flush    = 1'b0;
        in_valid = 1'b0;
        send(0, 1000, 1'b0);
        n_vec++; if (out_data !== 16'sd985) begin n_err++; $display("FAIL flush_restart: got %0d want 985", out_data); end
        n_vec++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL flush_sat: got %0d want 0", sat_count); end
    endtask

    task automatic test_bypass();
        // Continues from flush test: ch0 prev_in=1000, prev_out=985.
        send(0, 1234, 1'b1);
        n_vec++; if (out_data !== 16'sd1234) begin n_err++; $display("FAIL bypass_out: got %0d want 1234", out_data); end
        send(0, 1234, 1'b0);
        n_vec++; if (out_data !== 16'sd1182) begin n_err++; $display("FAIL bypass_next: got %0d want 1182", out_data); end
    endtask

    task automatic test_saturation();
        int y;
        logic [31:0] yv;
        logic [15:0] exp_d;
        logic [15:0] exp_s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            y = model_step(0, 32767);
            send(0, 32767, 1'b0);
            if (i == 0) begin
                n_vec++;
                if (out_data !== 16'sd32256) begin n_err++; $display("FAIL sat_first: got %0d want 32256", out_data); end
            end
        end
        y  = model_step(0, -32768);
        yv = y;
`ifdef HPF_SAT_EN
        exp_d = 16'h8000;
        exp_s = 16'd1;
`else
        exp_d = yv[15:0];
        exp_s = 16'd0;
`endif
        send(0, -32768, 1'b0);
        n_vec++; if (out_data !== exp_d) begin n_err++; $display("FAIL sat_out: got %0d want %0d (y=%0d)", out_data, $signed(exp_d), y); end
        n_vec++; if (sat_count !== exp_s) begin n_err++; $display("FAIL sat_count: got %0d want %0d", sat_count, exp_s); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        send(1, 500, 1'b0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_held: got %0b want 1", out_valid); end
        reset = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_chan !== 1'b0 || sat_count !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%0b d=%0d c=%0d s=%0d want all 0", out_valid, out_data, out_chan, sat_count);
        end
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        send(0, 1000, 1'b0);
        n_vec++; if (out_data !== 16'sd985) begin n_err++; $display("FAIL mid_ch0: got %0d want 985", out_data); end
        send(1, 1000, 1'b0);
        n_vec++; if (out_data !== 16'sd985) begin n_err++; $display("FAIL mid_ch1: got %0d want 985", out_data); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_chan   = '0;
        bypass    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_step();
        test_interleave();
        test_backpressure();
        test_flush();
        test_bypass();
        test_saturation();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
